dispatch_queue_array: RTL
=========================

Name: dispatch_queue_array

Overview:
- Per-pipeline dispatch buffering between the frontend's renamed-op outputs and the execution pipelines (alu, mem, term; generalised to CHANNELS).
- Replaces the tie-off of pipeline ready to 1 with real per-channel FIFOs and valid/ready backpressure, so pipelines can stall.
- Adds an optional same-cycle bypass mode, a global flush for mispredict/redirect, and occupancy reporting.

Parameters:
- CHANNELS, 3, number of independent op streams; channel 0 = alu, 1 = mem, 2 = term.
- OP_W, 32, width of one renamed op; instantiated with `RENAMED_OP_SZ.
- DEPTH, 4, entries per channel FIFO; power of two, >= 2.
- BYPASS, 0, 1 = an empty channel forwards its input combinationally in the same cycle.
- CNT_W, $clog2(DEPTH+1), width of each occupancy count (derived; do not override).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- flush  in  1  synchronous discard of all buffered ops in every channel.
- op_in  in  CHANNELS*OP_W  incoming ops; channel c occupies bits [c*OP_W +: OP_W].
- op_in_valid  in  CHANNELS  per-channel input valid.
- op_in_ready  out  CHANNELS  per-channel input ready, towards the frontend.
- op_out  out  CHANNELS*OP_W  head op of each channel; same packing as op_in.
- op_out_valid  out  CHANNELS  per-channel output valid, towards the pipelines.
- op_out_ready  in  CHANNELS  per-channel pipeline ready.
- occupancy  out  CHANNELS*CNT_W  stored entry count per channel, packed like op_in.
- all_empty  out  1  high when every channel count is 0.

Behaviour:
- Channels are fully independent and in-order (FIFO) within each channel. There is no ordering between channels.
- Push on channel c occurs when op_in_valid[c] && op_in_ready[c]. Pop occurs when op_out_valid[c] && op_out_ready[c].
- op_in_ready[c] = (count[c] != DEPTH) && rst && !flush. It is a function of registered state and these inputs only, with no path from op_out_ready.
- BYPASS=0:
  - op_out_valid[c] = (count[c] != 0) && !flush.
  - op_out = mem[c][rd_ptr[c]].
  - Latency from input to output is 1 cycle minimum.
- BYPASS=1:
  - When count[c] == 0, op_out_valid[c] = op_in_valid[c] && op_in_ready[c], and op_out mirrors op_in.
  - If op_out_ready[c] is also high, the op is consumed with no enqueue and the count stays 0.
  - If op_out_ready[c] is low, the op is enqueued normally.
  - When count[c] > 0, behaviour is identical to BYPASS=0.
- Simultaneous push and pop with 0 < count < DEPTH: the count is unchanged and both pointers advance.
- Full (count == DEPTH): op_in_ready is low, so no push occurs, even if a pop happens in the same cycle.
- Empty with BYPASS=0: op_out_valid is low and a push is visible on the next cycle.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- count is CNT_W bits and never exceeds DEPTH.
- flush (with rst high):
  - In the same cycle, op_in_ready and op_out_valid are forced low, so no push or pop occurs.
  - On the next edge all counts and pointers go to 0.
  - Storage contents are don't-care.
- Reset (rst low at an edge):
  - All counts and pointers go to 0.
  - While rst is low, op_in_ready = 0 and op_out_valid = 0.
  - Reset mid-transfer discards all entries. Nothing in flight survives.
- Reset values: op_in_ready = 0 while in reset and all 1s on the first cycle after; op_out_valid = 0; occupancy = 0; all_empty = 1. op_out data is don't-care when op_out_valid = 0.
- occupancy reports count[c] registered, so it excludes any same-cycle bypassed op.
- all_empty = AND over channels of (count[c] == 0).
- Storage is plain flops/registers with no reset on the data array. Reset and flush touch only control state.

Test Plan:
- Reset then fill: hold rst low 2 cycles, release, push 0xA1..0xA4 on channel 0 with op_out_ready[0] = 0 -> op_in_ready[0] drops after the 4th push; occupancy[0] = 4; channels 1 and 2 are unaffected (occupancy 0, ready 1).
- Drain order and wrap: continue from full with op_out_ready[0] = 1 while pushing 0xA5..0xA8 -> outputs appear 0xA1..0xA8 in order; the pointer wrap is invisible; all_empty = 1 after the last pop.
- Backpressure mid-stream: mem channel with op_out_ready toggling 1,0,1,0 while pushing every cycle -> no op is lost or duplicated; op_in_ready[1] = 0 exactly on the cycles where count = 4.
- Bypass: BYPASS=1, empty term channel, push 0x5C with op_out_ready[2] = 1 -> op_out_valid[2] = 1 in the same cycle with data 0x5C, and occupancy[2] stays 0. Repeat with ready = 0 -> occupancy[2] = 1 next cycle.
- Flush: load 3, 2 and 1 entries across channels, assert flush for 1 cycle while pushing and pulsing ready -> no handshake completes in the flush cycle; all occupancy values are 0 and all_empty = 1 on the next cycle.
- Reset mid-operation: rst low for 1 cycle while channel 0 holds 2 entries and op_out_valid = 1 -> op_out_valid = 0 immediately; after release, occupancy = 0 and the next pushed op is the first one output.

Source files
------------

// File: rtl/dispatch_queue_array.sv
// Per-channel in-order dispatch FIFOs between rename and the execution pipelines,
// with valid/ready backpressure, optional empty-channel bypass, flush and occupancy.
module dispatch_queue_array #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned OP_W     = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned BYPASS   = 0,
  parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [CHANNELS*OP_W-1:0]  op_in,
  input  logic [CHANNELS-1:0]       op_in_valid,
  output logic [CHANNELS-1:0]       op_in_ready,
  output logic [CHANNELS*OP_W-1:0]  op_out,
  output logic [CHANNELS-1:0]       op_out_valid,
  input  logic [CHANNELS-1:0]       op_out_ready,
  output logic [CHANNELS*CNT_W-1:0] occupancy,
  output logic                      all_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [OP_W-1:0]  mem    [CHANNELS][DEPTH];
  logic [CNT_W-1:0] count  [CHANNELS];
  logic [PTR_W-1:0] rd_ptr [CHANNELS];
  logic [PTR_W-1:0] wr_ptr [CHANNELS];

  logic [CHANNELS-1:0] accept;
  logic [CHANNELS-1:0] push;
  logic [CHANNELS-1:0] enq;
  logic [CHANNELS-1:0] pop;
  logic [CHANNELS-1:0] empty;
  logic [CHANNELS-1:0] fifo_vld;

  // Handshake decode; ready never depends on op_out_ready.
  always_comb begin
    accept    = '0;
    push      = '0;
    enq       = '0;
    pop       = '0;
    empty     = '0;
    fifo_vld  = '0;
    op_out    = '0;
    occupancy = '0;
    all_empty = 1'b1;
    for (int c = 0; c < CHANNELS; c++) begin
      empty[c]    = (count[c] == '0);
      accept[c]   = (count[c] != FULL_CNT) && rst && !flush;
      push[c]     = op_in_valid[c] && accept[c];
      fifo_vld[c] = !empty[c] && rst && !flush;
      occupancy[c*CNT_W +: CNT_W] = count[c];
      all_empty   = all_empty && empty[c];
      if ((BYPASS != 0) && empty[c]) begin
        // Empty channel forwards the input; it is stored only if the pipeline stalls.
        op_out[c*OP_W +: OP_W] = op_in[c*OP_W +: OP_W];
        enq[c] = push[c] && !op_out_ready[c];
      end else begin
        op_out[c*OP_W +: OP_W] = mem[c][rd_ptr[c]];
        enq[c] = push[c];
        pop[c] = fifo_vld[c] && op_out_ready[c];
      end
    end
  end

  always_comb begin
    op_in_ready  = accept;
    op_out_valid = fifo_vld;
    if (BYPASS != 0) begin
      op_out_valid = fifo_vld | (empty & push);
    end
  end

  // Control state: reset and flush clear counts and pointers only.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      for (int c = 0; c < CHANNELS; c++) begin
        count[c]  <= '0;
        rd_ptr[c] <= '0;
        wr_ptr[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (enq[c]) begin
          wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
        end
        if (pop[c]) begin
          rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
        end
        count[c] <= count[c] + CNT_W'(enq[c]) - CNT_W'(pop[c]);
      end
    end
  end

  // Data array carries no reset.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (enq[c]) begin
        mem[c][wr_ptr[c]] <= op_in[c*OP_W +: OP_W];
      end
    end
  end

endmodule
